uart_rx_deframer: RTL and testbench
===================================

Name: uart_rx_deframer

Overview:
- Serial receive front end of the UART.
- Oversamples the asynchronous Rx line at 16x baud, detects start bits, and shifts in data, parity and stop bits.
- Checks even parity, framing and break conditions.
- Presents each completed character with its error flags for one-cycle capture by the downstream Rx FIFO (Data_Out, Data_Rdy, Rx_Error).

Parameters:
- SYSCLK_RATE, 100000000: Clk frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bits/s.
- DATA_BITS, 8: data bits per character (1..8).
- PARITY_BIT, 1: 1 = one even-parity bit present; 0 = no parity bit, parity check disabled.
- STOP_BITS, 2: stop bits per character (1..2).
- DIV (localparam), SYSCLK_RATE/(BAUD_RATE*16): Clk cycles per oversample tick; must be >= 1.

Ports:
- Clk  input  1  system clock; all state on posedge.
- Rst  input  1  asynchronous, active-low reset.
- Rx  input  1  asynchronous serial line; idle high.
- Rx_Busy  output  1  high while a character is in progress (START..STOP, WAIT_IDLE).
- Data_Out  output  DATA_BITS  last completed character; held until the next Data_Rdy.
- Data_Rdy  output  1  one-Clk pulse; Data_Out and Rx_Error are valid in that cycle.
- Rx_Error  output  3  [0] break, [1] parity, [2] frame; updated with Data_Rdy and held.

Behaviour:
- Reset (Rst low, async): Data_Out=0, Data_Rdy=0, Rx_Error=000, Rx_Busy=0, state=IDLE, all counters 0, synchroniser flops=1.
- Rst mid-frame discards the partial character; no Data_Rdy is issued for it.
- Rx input synchroniser:
  - Two-flop synchroniser; all logic uses the second-stage value rxs.
  - Input-to-decision latency is 2 Clk.
- Tick generator:
  - Counter 0..DIV-1; tick asserted when the counter equals DIV-1, then wraps.
  - Counter forced to 0 in IDLE so the first tick follows the start edge by exactly DIV Clk.
- States:
  - IDLE: rxs falling (1 -> 0) -> START; clear the sample counter.
  - START: count ticks; on the 8th tick (mid-bit), rxs=0 -> DATA, else false start -> IDLE with no outputs.
  - DATA: every 16 ticks sample rxs. Bits arrive MSB first; the first data bit lands in Data_Out[DATA_BITS-1]. After DATA_BITS samples -> PARITY if PARITY_BIT=1, else STOP.
  - PARITY: sample after 16 ticks. Parity error if sampled bit != XOR of data bits.
  - STOP: sample STOP_BITS bits, one every 16 ticks. Any stop sample of 0 -> frame error.
- Completion:
  - After the last stop sample, registered on the next Clk: Data_Rdy=1 for exactly 1 Clk, Data_Out=shifted data, Rx_Error updated.
  - Then: -> IDLE if rxs=1, else -> WAIT_IDLE.
- Break:
  - Condition: all data samples, parity sample (if present) and all stop samples are 0.
  - Sets Rx_Error=001 only; frame and parity bits are suppressed.
  - Data_Out=0.
- WAIT_IDLE: remain until rxs=1, then IDLE. No start detection while Rx is held low, so a break yields exactly one Data_Rdy.
- Simultaneous parity and frame errors (not break): Rx_Error=110.
- Rx_Error bits are not sticky: each Data_Rdy overwrites all three.
- Rx_Busy=1 in every state except IDLE.
- No back-pressure. Downstream must accept on Data_Rdy; overflow is handled by the FIFO.

Test Plan:
Common setup: SYSCLK_RATE=1600000, BAUD_RATE=100000 (DIV=1, 16 Clk per bit), DATA_BITS=8, PARITY_BIT=1, STOP_BITS=2.
1. Frame 0xA5, parity 0, stop 11 -> exactly one Data_Rdy pulse, Data_Out=0xA5, Rx_Error=000, Rx_Busy low within 2 Clk of the pulse.
2. Frame 0xAA with parity bit 1 (correct is 0) -> Data_Out=0xAA, Rx_Error=010.
3. Frame 0xAA, parity 0, stop bits 00, then Rx high -> Rx_Error=100, Data_Rdy once, no spurious second start while stop bits are low.
4. Rx held low for 12 bit times, then high -> one Data_Rdy, Data_Out=0x00, Rx_Error=001, IDLE only after Rx rises.
5. Rx low for 4 Clk, then high (glitch) -> no Data_Rdy, Rx_Busy returns to 0, Rx_Error unchanged. A following valid 0x3C frame is received with Rx_Error=000.
6. Rst pulled low during the 4th data bit of 0x5A -> all outputs 0 immediately, no Data_Rdy. After release, frame 0x3C -> Data_Out=0x3C, Rx_Error=000.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 16x oversampling UART receiver with MSB-first data, even parity,
// frame and break detection, delivering each character as a one-cycle Data_Rdy pulse.
module uart_rx_deframer #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    output logic                 Rx_Busy,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error
);
    localparam int DIV = SYSCLK_RATE / (BAUD_RATE * 16);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t               state_q, state_d;
    logic                 s1_q, rxs_q, rxp_q;
    logic [DW-1:0]        div_q, div_d;
    logic [3:0]           cnt_q, cnt_d, bits_q, bits_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, dout_d;
    logic                 pe_q, pe_d, fe_q, fe_d, allz_q, allz_d, rdy_d;
    logic [2:0]           err_d;
    logic                 tick, samp;

    assign tick    = state_q != IDLE && div_q == DW'(DIV - 1);
    assign samp    = tick && cnt_q == 4'd15;
    assign Rx_Busy = state_q != IDLE;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            s1_q     <= 1'b1;
            rxs_q    <= 1'b1;
            rxp_q    <= 1'b1;
            div_q    <= '0;
            cnt_q    <= '0;
            bits_q   <= '0;
            shift_q  <= '0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
            allz_q   <= 1'b0;
            Data_Out <= '0;
            Data_Rdy <= 1'b0;
            Rx_Error <= '0;
        end else begin
            state_q  <= state_d;
            s1_q     <= Rx;
            rxs_q    <= s1_q;
            rxp_q    <= rxs_q;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            bits_q   <= bits_d;
            shift_q  <= shift_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
            allz_q   <= allz_d;
            Data_Out <= dout_d;
            Data_Rdy <= rdy_d;
            Rx_Error <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = (state_q == IDLE || tick) ? '0 : div_q + DW'(1);
        cnt_d   = tick ? cnt_q + 4'd1 : cnt_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        allz_d  = allz_q;
        rdy_d   = 1'b0;
        dout_d  = Data_Out;
        err_d   = Rx_Error;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bits_d = '0;
                pe_d   = 1'b0;
                fe_d   = 1'b0;
                allz_d = 1'b1;
                if (rxp_q && !rxs_q) state_d = START;
            end
            START: if (tick && cnt_q == 4'd7) begin
                cnt_d   = '0;
                state_d = rxs_q ? IDLE : DATA;
            end
            DATA: if (samp) begin
                shift_d = (shift_q << 1) | DATA_BITS'(rxs_q);
                allz_d  = allz_q & ~rxs_q;
                bits_d  = bits_q + 4'd1;
                if (bits_q == 4'(DATA_BITS - 1)) begin
                    bits_d  = '0;
                    state_d = PARITY_BIT != 0 ? PARITY : STOP;
                end
            end
            PARITY: if (samp) begin
                pe_d    = rxs_q ^ (^shift_q);
                allz_d  = allz_q & ~rxs_q;
                state_d = STOP;
            end
            STOP: if (samp) begin
                fe_d   = fe_q | ~rxs_q;
                allz_d = allz_q & ~rxs_q;
                bits_d = bits_q + 4'd1;
                // a fully-zero character is a break and masks parity/frame reporting
                if (bits_q == 4'(STOP_BITS - 1)) begin
                    rdy_d   = 1'b1;
                    dout_d  = allz_d ? '0 : shift_q;
                    err_d   = allz_d ? 3'b001 : {fe_d, pe_q, 1'b0};
                    state_d = rxs_q ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: if (rxs_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed frames at 16 Clk per bit with hand-computed expected characters and error flags.
module tb_uart_rx_deframer;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx  = 1'b1;
    logic       Rx_Busy, Data_Rdy;
    logic [7:0] Data_Out;
    logic [2:0] Rx_Error;

    int         n_cmp = 0, n_err = 0, rdy_cnt = 0;
    logic [7:0] cap_d = '0;
    logic [2:0] cap_e = '0;
    logic       cap_busy = 1'b1, prev_rdy = 1'b0;

    uart_rx_deframer #(
        .SYSCLK_RATE(1600000), .BAUD_RATE(100000),
        .DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Rx_Busy(Rx_Busy),
        .Data_Out(Data_Out), .Data_Rdy(Data_Rdy), .Rx_Error(Rx_Error)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (prev_rdy) cap_busy = Rx_Busy;
        if (Data_Rdy) begin
            rdy_cnt++;
            cap_d = Data_Out;
            cap_e = Rx_Error;
        end
        prev_rdy = Data_Rdy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_t(input logic b);
        Rx = b;
        repeat (16) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic [1:0] s);
        bit_t(1'b0);
        for (int i = 7; i >= 0; i--) bit_t(d[i]);
        bit_t(p);
        bit_t(s[1]);
        bit_t(s[0]);
    endtask

    task automatic idle(input int bits);
        for (int i = 0; i < bits; i++) bit_t(1'b1);
    endtask

    initial begin
        repeat (4) @(negedge Clk);
        check("rst_dout", Data_Out, 0);
        check("rst_rdy", Data_Rdy, 0);
        check("rst_err", Rx_Error, 0);
        check("rst_busy", Rx_Busy, 0);
        Rst = 1'b1;
        idle(2);

        rdy_cnt = 0;
        send(8'hA5, 1'b0, 2'b11);
        idle(2);
        check("t1_cnt", rdy_cnt, 1);
        check("t1_dout", cap_d, 8'hA5);
        check("t1_err", cap_e, 3'b000);
        check("t1_busy_after", cap_busy, 0);
        check("t1_hold", Data_Out, 8'hA5);

        rdy_cnt = 0;
        send(8'hAA, 1'b1, 2'b11);
        idle(2);
        check("t2_cnt", rdy_cnt, 1);
        check("t2_dout", cap_d, 8'hAA);
        check("t2_err", cap_e, 3'b010);

        rdy_cnt = 0;
        send(8'hAA, 1'b0, 2'b00);
        check("t3_busy_low", Rx_Busy, 1);
        idle(2);
        check("t3_cnt", rdy_cnt, 1);
        check("t3_dout", cap_d, 8'hAA);
        check("t3_err", cap_e, 3'b100);
        check("t3_idle", Rx_Busy, 0);

        rdy_cnt = 0;
        for (int i = 0; i < 12; i++) bit_t(1'b0);
        check("t4_cnt_low", rdy_cnt, 1);
        check("t4_wait_busy", Rx_Busy, 1);
        idle(2);
        check("t4_cnt", rdy_cnt, 1);
        check("t4_dout", cap_d, 8'h00);
        check("t4_err", cap_e, 3'b001);
        check("t4_idle", Rx_Busy, 0);

        rdy_cnt = 0;
        Rx = 1'b0;
        repeat (4) @(negedge Clk);
        Rx = 1'b1;
        idle(2);
        check("t5_glitch_cnt", rdy_cnt, 0);
        check("t5_glitch_busy", Rx_Busy, 0);
        check("t5_glitch_err", Rx_Error, 3'b001);
        send(8'h3C, 1'b0, 2'b11);
        idle(2);
        check("t5_cnt", rdy_cnt, 1);
        check("t5_dout", cap_d, 8'h3C);
        check("t5_err", cap_e, 3'b000);

        rdy_cnt = 0;
        bit_t(1'b0);
        bit_t(1'b0);
        bit_t(1'b1);
        bit_t(1'b0);
        Rx = 1'b1;
        repeat (8) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("t6_rst_dout", Data_Out, 0);
        check("t6_rst_err", Rx_Error, 0);
        check("t6_rst_busy", Rx_Busy, 0);
        check("t6_rst_rdy", Data_Rdy, 0);
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        idle(2);
        check("t6_no_rdy", rdy_cnt, 0);
        send(8'h3C, 1'b0, 2'b11);
        idle(2);
        check("t6_cnt", rdy_cnt, 1);
        check("t6_dout", cap_d, 8'h3C);
        check("t6_err", cap_e, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
